// File: rtl/vip_matrix_generate_3x3_8bit.sv
// Sliding 3x3 luma window generator with two line buffers and top/left edge padding.
// Optional macro MATRIX_EDGE_REPLICATE_EN: replicate edge pixels instead of zero padding.
module vip_matrix_generate_3x3_8bit #(
  parameter int unsigned IMG_HDISP = 640,
  parameter int unsigned IMG_VDISP = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic       matrix_frame_vsync,
  output logic       matrix_frame_href,
  output logic       matrix_frame_clken,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33
);

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned COL_W        = $clog2(IMG_HDISP + 1);
  localparam int unsigned ADDR_W       = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned LCNT_W       = 2;
  localparam int unsigned UNUSED_VDISP = IMG_VDISP;

  logic [1:0]              vsync_dly_q, vsync_dly_d;
  logic [1:0]              href_dly_q, href_dly_d;
  logic [1:0]              clken_dly_q, clken_dly_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [LCNT_W-1:0]       lcnt_q, lcnt_d;
  logic                    armed_q, armed_d;
  logic [2:0][PIX_W-1:0]   row_q, row_d;
  logic [2:0][2:0][PIX_W-1:0] p_q, p_d;
`ifdef MATRIX_EDGE_REPLICATE_EN
  logic                    first_q, first_d;
`endif

  logic [PIX_W-1:0]        lb1_mem [IMG_HDISP];
  logic [PIX_W-1:0]        lb2_mem [IMG_HDISP];
  logic [ADDR_W-1:0]       addr;
  logic                    col_ok;
  logic                    wr_en;
  logic [PIX_W-1:0]        lb1_rd;
  logic [PIX_W-1:0]        lb2_rd;
  logic                    vsync_rise;
  logic                    href_fall;

  assign addr       = ADDR_W'(col_q);
  assign col_ok     = (col_q < COL_W'(IMG_HDISP));
  assign wr_en      = per_frame_clken & per_frame_href & col_ok;
  assign lb1_rd     = col_ok ? lb1_mem[addr] : '0;
  assign lb2_rd     = col_ok ? lb2_mem[addr] : '0;
  assign vsync_rise = per_frame_vsync & ~vsync_dly_q[0];
  assign href_fall  = ~per_frame_href & href_dly_q[0];

  // Line buffers: LB2 takes LB1's previous content at the same address (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1_mem[addr] <= per_img_Y;
      lb2_mem[addr] <= lb1_mem[addr];
    end
  end

  // Sync delay lines and position counters.
  always_comb begin
    vsync_dly_d = {vsync_dly_q[0], per_frame_vsync};
    href_dly_d  = {href_dly_q[0], per_frame_href};
    clken_dly_d = {clken_dly_q[0], per_frame_clken};
    col_d       = col_q;
    lcnt_d      = lcnt_q;
    armed_d     = armed_q;
    if (!per_frame_href) begin
      col_d = '0;
    end else if (per_frame_clken && col_ok) begin
      col_d = col_q + COL_W'(1);
    end
    // vsync clear wins over a coincident href fall; lcnt stays 0 until a frame is seen.
    if (vsync_rise) begin
      lcnt_d  = '0;
      armed_d = 1'b1;
    end else if (href_fall && armed_q && (lcnt_q != LCNT_W'(2))) begin
      lcnt_d = lcnt_q + LCNT_W'(1);
    end
  end

  // Stage 1: sample the three vertical taps, masking rows not yet filled this frame.
  always_comb begin
    row_d = row_q;
    if (per_frame_clken) begin
      row_d[2] = per_img_Y;
`ifdef MATRIX_EDGE_REPLICATE_EN
      if (lcnt_q == LCNT_W'(0)) begin
        row_d[1] = per_img_Y;
        row_d[0] = per_img_Y;
      end else if (lcnt_q == LCNT_W'(1)) begin
        row_d[1] = lb1_rd;
        row_d[0] = lb1_rd;
      end else begin
        row_d[1] = lb1_rd;
        row_d[0] = lb2_rd;
      end
`else
      row_d[1] = (lcnt_q >= LCNT_W'(1)) ? lb1_rd : '0;
      row_d[0] = (lcnt_q >= LCNT_W'(2)) ? lb2_rd : '0;
`endif
    end
  end

  // Stage 2: horizontal shift; window cleared between lines for left-edge padding.
  always_comb begin
    p_d = p_q;
`ifdef MATRIX_EDGE_REPLICATE_EN
    first_d = first_q;
`endif
    if (!href_dly_q[0]) begin
      p_d = '0;
`ifdef MATRIX_EDGE_REPLICATE_EN
      first_d = 1'b1;
`endif
    end else if (clken_dly_q[0]) begin
`ifdef MATRIX_EDGE_REPLICATE_EN
      first_d = 1'b0;
`endif
      for (int r = 0; r < 3; r++) begin
        p_d[r][0] = p_q[r][1];
        p_d[r][1] = p_q[r][2];
        p_d[r][2] = row_q[r];
`ifdef MATRIX_EDGE_REPLICATE_EN
        if (first_q) begin
          p_d[r][0] = row_q[r];
          p_d[r][1] = row_q[r];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_dly_q <= '0;
      href_dly_q  <= '0;
      clken_dly_q <= '0;
      col_q       <= '0;
      lcnt_q      <= '0;
      armed_q     <= 1'b0;
      row_q       <= '0;
      p_q         <= '0;
`ifdef MATRIX_EDGE_REPLICATE_EN
      first_q     <= 1'b0;
`endif
    end else begin
      vsync_dly_q <= vsync_dly_d;
      href_dly_q  <= href_dly_d;
      clken_dly_q <= clken_dly_d;
      col_q       <= col_d;
      lcnt_q      <= lcnt_d;
      armed_q     <= armed_d;
      row_q       <= row_d;
      p_q         <= p_d;
`ifdef MATRIX_EDGE_REPLICATE_EN
      first_q     <= first_d;
`endif
    end
  end

  assign matrix_frame_vsync = vsync_dly_q[1];
  assign matrix_frame_href  = href_dly_q[1];
  assign matrix_frame_clken = clken_dly_q[1];
  assign matrix_p11 = p_q[0][0];
  assign matrix_p12 = p_q[0][1];
  assign matrix_p13 = p_q[0][2];
  assign matrix_p21 = p_q[1][0];
  assign matrix_p22 = p_q[1][1];
  assign matrix_p23 = p_q[1][2];
  assign matrix_p31 = p_q[2][0];
  assign matrix_p32 = p_q[2][1];
  assign matrix_p33 = p_q[2][2];

endmodule
